// File: rtl/m_mem_master_pkg.sv
//------------------------------------------------------------------------------
// Module  : m_mem_master_pkg
// Brief   : Shared data-memory op codes and M-stage bus master state encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package m_mem_master_pkg;

  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_HU = 3'd2;
  localparam logic [2:0] DM_B  = 3'd3;
  localparam logic [2:0] DM_BU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Unknown op codes fall through to the word case, matching the lane logic.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    logic r;
    case (op)
      DM_B, DM_BU: r = 1'b0;
      DM_H, DM_HU: r = addr_lo[0];
      default:     r = (addr_lo != 2'b00);
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/m_mem_lane.sv
//------------------------------------------------------------------------------
// Module  : m_mem_lane
// Brief   : Byte-enable / store-lane replication and load extract/extend.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module m_mem_lane
  import m_mem_master_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_lanes,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_rdata_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    st_be          = 4'b1111;
    st_wdata_lanes = st_wdata;
    case (st_op)
      DM_B, DM_BU: begin
        st_be          = 4'b0001 << st_addr_lo;
        st_wdata_lanes = {4{st_wdata[7:0]}};
      end
      DM_H, DM_HU: begin
        st_be          = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata_lanes = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte       = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
    w_half       = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_rdata_ext = ld_rdata;
    case (ld_op)
      DM_B:    ld_rdata_ext = {{24{w_byte[7]}}, w_byte};
      DM_BU:   ld_rdata_ext = {24'd0, w_byte};
      DM_H:    ld_rdata_ext = {{16{w_half[15]}}, w_half};
      DM_HU:   ld_rdata_ext = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/m_mem_master.sv
//------------------------------------------------------------------------------
// Module  : m_mem_master
// Brief   : M-stage data-memory bus initiator; one load/store per request.
//           Define MEM_ALIGN_CHECK_EN to reject misaligned h/w accesses.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module m_mem_master
  import m_mem_master_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int                 c_cnt_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_we;
  logic [2:0]         r_op;
  logic [1:0]         r_addr_lo;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_accept;
  logic               w_misaligned;
  logic               w_timeout;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata_lanes;
  logic [31:0]        w_ld_data;

  m_mem_lane u_lane (
    .st_op          (req_op),
    .st_addr_lo     (req_addr[1:0]),
    .st_wdata       (req_wdata),
    .st_be          (w_be),
    .st_wdata_lanes (w_wdata_lanes),
    .ld_op          (r_op),
    .ld_addr_lo     (r_addr_lo),
    .ld_rdata       (bus_rdata),
    .ld_rdata_ext   (w_ld_data)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = is_misaligned(req_op, req_addr[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_timeout = (r_cnt == c_cnt_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Bus strobes decode directly from state so reset drops them without a clock.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    busy        = 1'b1;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) w_state_nxt = w_misaligned ? ST_RESP : ST_BUS;
      end
      ST_BUS: begin
        bus_req = 1'b1;
        bus_we  = r_we;
        if (bus_ack || w_timeout) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we      <= 1'b0;
      r_op      <= DM_W;
      r_addr_lo <= 2'b00;
      r_cnt     <= '0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we      <= req_we;
            r_op      <= req_op;
            r_addr_lo <= req_addr[1:0];
            r_cnt     <= '0;
            bus_addr  <= {req_addr[31:2], 2'b00};
            bus_be    <= w_be;
            bus_wdata <= w_wdata_lanes;
            rsp_rdata <= 32'd0;
            rsp_err   <= w_misaligned;
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= r_we ? 32'd0 : w_ld_data;
          end else if (w_timeout) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_m_mem_master.sv
//------------------------------------------------------------------------------
// Module  : tb_m_mem_master
// Brief   : Directed self-checking bench for m_mem_master (TIMEOUT = 16).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_m_mem_master;
  import m_mem_master_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, busy, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int checks   = 0;
  int failures = 0;

  m_mem_master #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request at the negedge; returns #1 after the accepting edge.
  task automatic send(input logic we, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wd);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_op = DM_W; req_addr = 32'd0; req_wdata = 32'd0;
  endtask

  task automatic check_bus(input string t, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
    chk({t, "_bus_req"},   bus_req, 1);
    chk({t, "_busy"},      busy, 1);
    chk({t, "_bus_we"},    bus_we, we);
    chk({t, "_bus_addr"},  bus_addr, addr);
    chk({t, "_bus_be"},    bus_be, be);
    chk({t, "_bus_wdata"}, bus_wdata, wd);
  endtask

  task automatic ack(input logic [31:0] rd);
    bus_ack = 1'b1; bus_rdata = rd;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'd0;
  endtask

  task automatic check_rsp(input string t, input logic [31:0] rd, input logic err);
    chk({t, "_rsp_valid"}, rsp_valid, 1);
    chk({t, "_bus_req_resp"}, bus_req, 0);
    chk({t, "_rsp_rdata"}, rsp_rdata, rd);
    chk({t, "_rsp_err"},   rsp_err, err);
    @(posedge clk); #1;
    chk({t, "_rsp_pulse"}, rsp_valid, 0);
    chk({t, "_back_idle"}, req_ready, 1);
  endtask

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = DM_W;
    req_addr = 32'd0; req_wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    @(negedge clk); reset = 1'b0;

    send(1'b1, DM_B, 32'h0000_1001, 32'h0000_00AB);
    check_bus("sb", 1'b1, 32'h0000_1000, 4'b0010, 32'hABAB_ABAB);
    ack(32'h0);
    check_rsp("sb", 32'h0, 1'b0);

    send(1'b0, DM_B, 32'h0000_2003, 32'h0);
    check_bus("lb3", 1'b0, 32'h0000_2000, 4'b1000, 32'h0);
    ack(32'h8011_2233);
    check_rsp("lb3", 32'hFFFF_FF80, 1'b0);

    send(1'b0, DM_BU, 32'h0000_2003, 32'h0);
    ack(32'h8011_2233);
    check_rsp("lbu3", 32'h0000_0080, 1'b0);

    send(1'b0, DM_B, 32'h0000_2000, 32'h0);
    check_bus("lb0", 1'b0, 32'h0000_2000, 4'b0001, 32'h0);
    ack(32'h8011_2233);
    check_rsp("lb0", 32'h0000_0033, 1'b0);

    send(1'b0, DM_H, 32'h0000_2002, 32'h0);
    check_bus("lh", 1'b0, 32'h0000_2000, 4'b1100, 32'h0);
    ack(32'h8001_5555);
    check_rsp("lh", 32'hFFFF_8001, 1'b0);

    send(1'b0, DM_HU, 32'h0000_2002, 32'h0);
    ack(32'h8001_5555);
    check_rsp("lhu", 32'h0000_8001, 1'b0);

    send(1'b1, DM_H, 32'h0000_2002, 32'h0000_1234);
    check_bus("sh", 1'b1, 32'h0000_2000, 4'b1100, 32'h1234_1234);
    ack(32'h0);
    check_rsp("sh", 32'h0, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
    send(1'b0, DM_W, 32'h0000_3002, 32'h0);
    chk("lw_mis_bus_req", bus_req, 0);
    check_rsp("lw_mis", 32'h0, 1'b1);
`else
    send(1'b0, DM_W, 32'h0000_3002, 32'h0);
    check_bus("lw_mis", 1'b0, 32'h0000_3000, 4'b1111, 32'h0);
    ack(32'hDEAD_BEEF);
    check_rsp("lw_mis", 32'hDEAD_BEEF, 1'b0);
`endif

    send(1'b1, 3'd7, 32'h0000_0010, 32'hCAFE_F00D);
    check_bus("sw_unk", 1'b1, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D);
    ack(32'h0);
    check_rsp("sw_unk", 32'h0, 1'b0);

    // No ack: response must appear after exactly 16 BUS cycles.
    send(1'b0, DM_W, 32'h0000_0040, 32'h0);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_cycles", n, 16);
    check_rsp("timeout", 32'h0, 1'b1);

    send(1'b0, DM_W, 32'h0000_0044, 32'h0);
    repeat (15) begin @(posedge clk); #1; end
    chk("ack16_still_bus", bus_req, 1);
    ack(32'h1122_3344);
    check_rsp("ack16", 32'h1122_3344, 1'b0);

    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    chk("stray_ack_rsp", rsp_valid, 0);
    chk("stray_ack_busy", busy, 0);

    send(1'b0, DM_W, 32'h0000_0050, 32'h0);
    chk("midrst_bus_req_before", bus_req, 1);
    #2 reset = 1'b1;
    #1 chk("midrst_bus_req_async", bus_req, 0);
    @(posedge clk); #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_no_rsp", rsp_valid, 0);
    chk("midrst_ready", req_ready, 1);
    send(1'b0, DM_W, 32'h0000_0060, 32'h0);
    check_bus("post_rst", 1'b0, 32'h0000_0060, 4'b1111, 32'h0);
    ack(32'h5A5A_5A5A);
    check_rsp("post_rst", 32'h5A5A_5A5A, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
